// File: rtl/serial_adder.sv
// serial_adder: bit-serial ripple adder, one operand bit per clock, LSB first.
// Latency: start presented in cycle 0, WIDTH busy cycles, done pulses in cycle WIDTH+1.
// Backpressure: none. start is only sampled in IDLE or DONE and is ignored while busy.
//
// Ports:
//   clk, rst       - clock; synchronous active-high reset
//   start          - begin an operation; a, b, cin (and sub) are captured with it
//   a, b, cin      - operands and carry-in
//   sub            - present only when SERIAL_ADDER_SUB_EN is defined: a - b = a + ~b + 1
//   sum/cout/ovf   - registered result, carry-out and signed overflow, held after done
//   busy           - high while bits are being computed
//   done           - one-cycle result-valid pulse
// Optional feature macro: SERIAL_ADDER_SUB_EN (adds the sub port and subtract mode).
`timescale 1ns/1ps
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic             carry;
  logic             cout_q;
  logic             ovf_q;
  logic             sub_in;

`ifdef SERIAL_ADDER_SUB_EN
  assign sub_in = sub;
`else
  assign sub_in = 1'b0;
`endif

  // Current bit slice. a_q/b_q rotate right each RUN cycle, so bit 0 is
  // always the bit being added, and on the last RUN cycle bit 0 holds the
  // original MSB -- that is what the overflow term needs.
  logic sbit;
  logic cnext;
  logic last_bit;

  assign sbit     = a_q[0] ^ b_q[0] ^ carry;
  assign cnext    = (a_q[0] & b_q[0]) | (a_q[0] & carry) | (b_q[0] & carry);
  assign last_bit = (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      carry  <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            a_q   <= a;
            // Subtract stores the effective operand ~b and forces carry-in 1.
            b_q   <= sub_in ? ~b : b;
            carry <= sub_in ? 1'b1 : cin;
            cnt   <= '0;
            state <= ST_RUN;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          sum_q <= {sbit, sum_q[WIDTH-1:1]};
          a_q   <= {a_q[0], a_q[WIDTH-1:1]};
          b_q   <= {b_q[0], b_q[WIDTH-1:1]};
          carry <= cnext;
          cnt   <= cnt + 1'b1;
          if (last_bit) begin
            state  <= ST_DONE;
            cout_q <= cnext;
            // Same-sign operands whose result sign differs.
            ovf_q  <= (a_q[0] == b_q[0]) && (sbit != a_q[0]);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;
  assign busy = (state == ST_RUN);
  assign done = (state == ST_DONE);

endmodule
